// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared types and helpers for the bf8b execute stage.
//               - op_t    : operation codes presented by decode
//               - state_t : execute-stage sequencer states
//               - counter-width helpers for the LOAD/STORE wait counters
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_ADD   = 3'b011,
        OP_SUB   = 3'b100,
        OP_INC   = 3'b101,
        OP_DEC   = 3'b110,
        OP_RSVD  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD_W  = 2'd1,
        S_STORE_W = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Bits needed to hold a wait count in the range 1..wait_cycles.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 2) ? 1 : $clog2(wait_cycles + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter widths for the default LOAD_WAIT / STORE_WAIT settings.
    localparam int C_LOAD_CNT_W_DEF  = cnt_width(2);
    localparam int C_STORE_CNT_W_DEF = cnt_width(1);

endpackage
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
// Module      : exec_alu
// Description : Combinational arithmetic for the execute stage.
//               Ports:
//                 op     in  op_t    operation code
//                 val1   in  DATA_W  first operand
//                 val2   in  DATA_W  second operand
//                 result out DATA_W  result, modulo 2^DATA_W
//                 carry  out 1       carry-out (ADD/INC) or borrow (SUB/DEC)
//                 zero   out 1       result == 0
//               Non-arithmetic ops produce an all-zero result.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    // One extra bit catches carry-out; for subtraction it goes high exactly
    // when the unsigned difference wraps, i.e. on a borrow.
    logic [DATA_W:0] w_wide;

    always_comb begin
        w_wide = '0;
        case (op)
            OP_ADD:  w_wide = {1'b0, val1} + {1'b0, val2};
            OP_SUB:  w_wide = {1'b0, val1} - {1'b0, val2};
            OP_INC:  w_wide = {1'b0, val1} + (DATA_W+1)'(1);
            OP_DEC:  w_wide = {1'b0, val1} - (DATA_W+1)'(1);
            default: w_wide = '0;
        endcase
    end

    assign result = w_wide[DATA_W-1:0];
    assign carry  = w_wide[DATA_W];
    assign zero   = (w_wide[DATA_W-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : exec_unit
// Description : bf8b execute stage. One operation per start/done handshake:
//               ALU arithmetic, data-memory load with LOAD_WAIT wait states,
//               or data-memory store holding we for STORE_WAIT cycles.
//               Ports:
//                 clk, rst            clock / async active-high reset
//                 start               request, sampled only in IDLE
//                 op                  operation code (see exec_pkg::op_t)
//                 val1, val2          operands
//                 addr_in             cell address from decode
//                 mem_data_in         memory read data
//                 busy                high whenever not IDLE
//                 done                one-cycle completion pulse
//                 err                 reserved op flag, valid with done
//                 val_out, zf, cf     held result and flags
//                 mem_addr            {PAGE, addr_in}
//                 mem_data_out, we    store data / write enable
// Revision    : 1.0 - initial release
// ============================================================================
module exec_unit
    import exec_pkg::*;
#(
    parameter int                     DATA_W     = 8,
    parameter int                     ADDR_W     = 8,
    parameter int                     CELL_W     = 5,
    parameter logic [ADDR_W-CELL_W-1:0] PAGE     = '1,
    parameter int                     LOAD_WAIT  = 2,
    parameter int                     STORE_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [CELL_W-1:0] addr_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] val_out,
    output logic              zf,
    output logic              cf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              we
);

    localparam int C_LOAD_CNT_W  = cnt_width(LOAD_WAIT);
    localparam int C_STORE_CNT_W = cnt_width(STORE_WAIT);
    localparam int C_CNT_W       = max_int(C_LOAD_CNT_W, C_STORE_CNT_W);

    generate
        if (CELL_W >= ADDR_W) begin : g_bad_cell_w
            $error("exec_unit: CELL_W must be less than ADDR_W");
        end
        if (LOAD_WAIT < 1) begin : g_bad_load_wait
            $error("exec_unit: LOAD_WAIT must be at least 1");
        end
        if (STORE_WAIT < 1) begin : g_bad_store_wait
            $error("exec_unit: STORE_WAIT must be at least 1");
        end
    endgenerate

    op_t               w_op;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic              w_alu_zero;

    state_t            r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_val;
    logic              r_zf;
    logic              r_cf;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_we;

    assign w_op = op_t'(op);

    exec_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (w_op),
        .val1   (val1),
        .val2   (val2),
        .result (w_alu_result),
        .carry  (w_alu_carry),
        .zero   (w_alu_zero)
    );

    // The wait counter is loaded with the full wait count on entry; the
    // cycle in which it reads 1 is the last wait cycle, so the completing
    // action lands exactly LOAD_WAIT / STORE_WAIT edges after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_val      <= '0;
            r_zf       <= 1'b0;
            r_cf       <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_we       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_err  <= 1'b0;
                        case (w_op)
                            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                                r_val   <= w_alu_result;
                                r_cf    <= w_alu_carry;
                                r_zf    <= w_alu_zero;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                            OP_LOAD: begin
                                r_mem_addr <= {PAGE, addr_in};
                                r_we       <= 1'b0;
                                r_cnt      <= C_CNT_W'(LOAD_WAIT);
                                r_state    <= S_LOAD_W;
                            end
                            OP_STORE: begin
                                r_mem_addr <= {PAGE, addr_in};
                                r_mem_data <= val1;
                                r_we       <= 1'b1;
                                r_cnt      <= C_CNT_W'(STORE_WAIT);
                                r_state    <= S_STORE_W;
                            end
                            OP_RSVD: begin
                                r_err   <= 1'b1;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                            default: begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_LOAD_W: begin
                    if (r_cnt == C_CNT_W'(1)) begin
                        r_val   <= mem_data_in;
                        r_zf    <= (mem_data_in == '0);
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                S_STORE_W: begin
                    if (r_cnt == C_CNT_W'(1)) begin
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign val_out      = r_val;
    assign zf           = r_zf;
    assign cf           = r_cf;
    assign mem_addr     = r_mem_addr;
    assign mem_data_out = r_mem_data;
    assign we           = r_we;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_unit
// Description : Scoreboard bench for exec_unit (LOAD_WAIT=2, STORE_WAIT=3).
//               Stimulus pushes the expected completion into a queue; a
//               monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] val1 = 8'h00;
    logic [7:0] val2 = 8'h00;
    logic [4:0] addr_in = 5'h00;
    logic [7:0] mem_data_in;
    logic       busy, done, err, zf, cf, we;
    logic [7:0] val_out, mem_addr, mem_data_out;

    exec_unit #(
        .DATA_W     (8),
        .ADDR_W     (8),
        .CELL_W     (5),
        .PAGE       (3'b111),
        .LOAD_WAIT  (2),
        .STORE_WAIT (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .val1         (val1),
        .val2         (val2),
        .addr_in      (addr_in),
        .mem_data_in  (mem_data_in),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .val_out      (val_out),
        .zf           (zf),
        .cf           (cf),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .we           (we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tiny memory: 0xE3 holds 0x5A, 0xFF holds whatever was last stored there.
    logic [7:0] st_data;
    always @(posedge clk) if (we && mem_addr == 8'hFF) st_data <= mem_data_out;
    assign mem_data_in = (mem_addr == 8'hE3) ? 8'h5A :
                         (mem_addr == 8'hFF) ? st_data : 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] v;
        bit         z;
        bit         c;
        bit         e;
        int         due;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t m;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                m = q.pop_front();
                check({m.tag, "_val"},  32'(val_out), 32'(m.v));
                check({m.tag, "_zf"},   32'(zf),      32'(m.z));
                check({m.tag, "_cf"},   32'(cf),      32'(m.c));
                check({m.tag, "_err"},  32'(err),     32'(m.e));
                check({m.tag, "_done_cycle"}, 32'(cyc), 32'(m.due));
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle 1 (after edge 0).
    task automatic issue(input string tag, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [4:0] ad, input bit push,
                         input logic [7:0] ev, input bit ez, input bit ec, input bit ee,
                         input int lat);
        exp_t x;
        x.v = ev; x.z = ez; x.c = ec; x.e = ee; x.due = cyc + lat; x.tag = tag;
        if (push) q.push_back(x);
        op = o; val1 = a; val2 = b; addr_in = ad; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 20; k++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        if (k == 20) check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err",  32'(err),  0);
        check("rst_we",   32'(we),   0);
        check("rst_zf",   32'(zf),   0);
        check("rst_cf",   32'(cf),   0);
        check("rst_val",  32'(val_out), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdat", 32'(mem_data_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // ALU ops: op, v1, v2, expected val/zf/cf
        issue("add_ff_01", 3'b011, 8'hFF, 8'h01, 5'h00, 1, 8'h00, 1, 1, 0, 1); wait_idle("add1");
        issue("sub_00_01", 3'b100, 8'h00, 8'h01, 5'h00, 1, 8'hFF, 0, 1, 0, 1); wait_idle("sub1");
        issue("dec_05",    3'b110, 8'h05, 8'h00, 5'h00, 1, 8'h04, 0, 0, 0, 1); wait_idle("dec1");
        issue("inc_ff",    3'b101, 8'hFF, 8'h00, 5'h00, 1, 8'h00, 1, 1, 0, 1); wait_idle("inc1");
        issue("add_12_34", 3'b011, 8'h12, 8'h34, 5'h00, 1, 8'h46, 0, 0, 0, 1); wait_idle("add2");
        issue("sub_03_05", 3'b100, 8'h03, 8'h05, 5'h00, 1, 8'hFE, 0, 1, 0, 1); wait_idle("sub2");

        // LOAD 0x03 -> 0xE3 returns 0x5A; cf stays 1; stray start ignored
        issue("load_e3", 3'b001, 8'h00, 8'h00, 5'h03, 1, 8'h5A, 0, 1, 0, 3);
        check("load_addr_c1", 32'(mem_addr), 32'h E3);
        check("load_we_c1",   32'(we), 0);
        op = 3'b011; val1 = 8'h01; val2 = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_addr_c2", 32'(mem_addr), 32'hE3);
        check("load_we_c2",   32'(we), 0);
        check("load_busy_c2", 32'(busy), 1);
        wait_idle("load1");

        // STORE 0x77 to 0x1F -> 0xFF, we high cycles 1..3, done cycle 4
        issue("store_ff", 3'b010, 8'h77, 8'h00, 5'h1F, 1, 8'h5A, 0, 1, 0, 4);
        for (int i = 1; i <= 3; i++) begin
            check("store_we",   32'(we), 1);
            check("store_addr", 32'(mem_addr), 32'hFF);
            check("store_wdat", 32'(mem_data_out), 32'h77);
            @(negedge clk);
        end
        check("store_we_c4", 32'(we), 0);
        wait_idle("store1");

        // Read back the stored byte
        issue("load_ff", 3'b001, 8'h00, 8'h00, 5'h1F, 1, 8'h77, 0, 1, 0, 3); wait_idle("load2");

        // Reserved op: err with done, val/flags unchanged; NOP clears err
        issue("rsvd", 3'b111, 8'hAA, 8'h55, 5'h00, 1, 8'h77, 0, 1, 1, 1); wait_idle("rsvd1");
        check("err_held", 32'(err), 1);
        issue("nop",  3'b000, 8'hAA, 8'h55, 5'h00, 1, 8'h77, 0, 1, 0, 1); wait_idle("nop1");

        // LOAD of a zero cell sets zf
        issue("load_zero", 3'b001, 8'h00, 8'h00, 5'h00, 1, 8'h00, 1, 1, 0, 3); wait_idle("load3");

        // Reset in cycle 2 of a STORE: we drops at once, no done
        issue("store_abort", 3'b010, 8'h33, 8'h00, 5'h1F, 0, 8'h00, 0, 0, 0, 4);
        check("abort_we_c1", 32'(we), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_we_now",   32'(we), 0);
        check("abort_busy_now", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_val", 32'(val_out), 0);

        issue("add_80_80", 3'b011, 8'h80, 8'h80, 5'h00, 1, 8'h00, 1, 1, 0, 1); wait_idle("add3");
        issue("add_01_02", 3'b011, 8'h01, 8'h02, 5'h00, 1, 8'h03, 0, 0, 0, 1); wait_idle("add4");

        repeat (3) @(negedge clk);
        check("pending_expectations", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
